// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares one single-ported memory between LC3 fetch and data requesters
module lc3_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instrmem_rd,
  input  logic [15:0] pc,
  input  logic        Data_req,
  input  logic        Data_rd,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  output logic        mem_en,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_timeout
);
  localparam logic [3:0] SL = 4'(STARVE_LIMIT);
  localparam logic [7:0] AT = 8'(ACK_TIMEOUT);
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;
  state_t     state;
  logic [3:0] starve_cnt;
  logic [7:0] tcnt;
  logic       pick_i, expire;
  assign pick_i = instrmem_rd & (~Data_req | (starve_cnt == SL));
  assign expire = (tcnt + 8'd1) == AT;
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      tcnt           <= '0;
      Instr_dout     <= '0;
      Data_dout      <= '0;
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      mem_en         <= 1'b0;
      mem_rd         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_timeout    <= 1'b0;
    end else begin
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      case (state)
        IDLE: if (instrmem_rd || Data_req) begin
          mem_en <= 1'b1;
          tcnt   <= '0;
          if (pick_i) begin
            state      <= BUSY_I;
            mem_addr   <= pc;
            mem_rd     <= 1'b1;
            starve_cnt <= '0;
          end else begin
            state    <= BUSY_D;
            mem_addr <= Data_addr;
            mem_rd   <= Data_rd;
            if (!Data_rd) mem_wdata <= Data_din;
            if (instrmem_rd && starve_cnt != SL) starve_cnt <= starve_cnt + 4'd1;
          end
        end
        BUSY_I, BUSY_D: if (mem_ack || expire) begin
          // a missing ack completes with an LC3 NOP (all zeros) as read data
          mem_en <= 1'b0;
          tcnt   <= '0;
          if (!mem_ack) mem_timeout <= 1'b1;
          if (state == BUSY_I) begin
            state          <= RESP_I;
            complete_instr <= 1'b1;
            Instr_dout     <= mem_ack ? mem_rdata : 16'h0000;
          end else begin
            state         <= RESP_D;
            complete_data <= 1'b1;
            if (mem_rd) Data_dout <= mem_ack ? mem_rdata : 16'h0000;
          end
        end else tcnt <= tcnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb_lc3_mem_arbiter: directed stimulus with a cycle-arithmetic transaction model checked every cycle
module tb_lc3_mem_arbiter;
  localparam int SLIM = 4;
  localparam int ATO  = 15;
  logic clock = 0;
  logic reset = 1;
  logic instrmem_rd = 0, Data_req = 0, Data_rd = 0;
  logic [15:0] pc = 0, Data_addr = 0, Data_din = 0;
  logic [15:0] Instr_dout, Data_dout, mem_addr, mem_wdata, mem_rdata;
  logic complete_instr, complete_data, mem_en, mem_rd, mem_timeout;
  logic mem_ack = 0;
  logic [15:0] rdata_val = 0;
  int wait_n = 0;
  bit no_ack = 0, stray = 0;
  int bcnt = 0;
  int tests = 0, fails = 0;

  lc3_mem_arbiter #(.STARVE_LIMIT(SLIM), .ACK_TIMEOUT(ATO)) dut (
    .clock(clock), .reset(reset), .instrmem_rd(instrmem_rd), .pc(pc),
    .Data_req(Data_req), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Instr_dout(Instr_dout), .complete_instr(complete_instr), .Data_dout(Data_dout),
    .complete_data(complete_data), .mem_en(mem_en), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_timeout(mem_timeout));

  always #5 clock = ~clock;
  assign mem_rdata = rdata_val;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // memory responder: ack after wait_n wait states unless no_ack; stray drives ack while idle
  always @(negedge clock) begin
    if (mem_en !== 1'b1) begin
      bcnt = 0;
      mem_ack = stray;
    end else begin
      mem_ack = !no_ack && bcnt == wait_n;
      bcnt++;
    end
  end

  // model: an access granted at edge g finishes at the first edge g+k with ack or k == ATO;
  // the arbiter may grant again only two edges after a finish
  int cyc = 0, live_start = 0, done_at = -10, skips = 0;
  bit started = 0, live = 0, live_i = 0;
  bit m_ci, m_cd, m_en, m_rd, m_to;
  logic [15:0] m_idout, m_ddout, m_addr, m_wdata;
  always @(posedge clock) begin
    cyc++;
    started = 1;
    m_ci = 0;
    m_cd = 0;
    if (reset) begin
      live = 0; done_at = -10; skips = 0;
      m_idout = 0; m_ddout = 0; m_addr = 0; m_wdata = 0;
      m_rd = 0; m_en = 0; m_to = 0;
    end else if (live) begin
      if (mem_ack || cyc - live_start == ATO) begin
        live = 0; done_at = cyc; m_en = 0;
        if (!mem_ack) m_to = 1;
        if (live_i) begin m_ci = 1; m_idout = mem_ack ? mem_rdata : 16'h0000; end
        else begin m_cd = 1; if (m_rd) m_ddout = mem_ack ? mem_rdata : 16'h0000; end
      end
    end else if (cyc - done_at >= 2 && (instrmem_rd || Data_req)) begin
      live = 1; live_start = cyc; m_en = 1;
      live_i = instrmem_rd && (!Data_req || skips == SLIM);
      if (live_i) begin
        skips = 0; m_addr = pc; m_rd = 1;
      end else begin
        if (instrmem_rd && skips < SLIM) skips++;
        m_addr = Data_addr; m_rd = Data_rd;
        if (!Data_rd) m_wdata = Data_din;
      end
    end
  end

  always @(negedge clock) if (started) begin
    check("complete_instr", complete_instr, m_ci);
    check("complete_data", complete_data, m_cd);
    check("both_complete", complete_instr & complete_data, 0);
    check("mem_en", mem_en, m_en);
    check("mem_rd", mem_rd, m_rd);
    check("mem_addr", mem_addr, m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("Instr_dout", Instr_dout, m_idout);
    check("Data_dout", Data_dout, m_ddout);
    check("mem_timeout", mem_timeout, m_to);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic xfer(input bit is_i, output int en_n, output int lat);
    en_n = 0;
    lat = 0;
    if (is_i) instrmem_rd = 1; else Data_req = 1;
    do begin
      @(negedge clock);
      lat++;
      en_n += int'(mem_en);
    end while (!(is_i ? complete_instr : complete_data) && lat < 60);
    if (is_i) instrmem_rd = 0; else Data_req = 0;
    check("xfer_bound", lat < 60, 1);
  endtask

  initial begin
    int en_n, lat, guard;
    bit prev_en;
    string glog;
    tick(2);
    check("rst_mem_en", mem_en, 0);
    check("rst_instr_dout", Instr_dout, 0);
    check("rst_timeout", mem_timeout, 0);
    reset = 0;
    tick(1);
    // zero-wait fetch
    pc = 16'h3000; rdata_val = 16'h1261; wait_n = 0;
    xfer(1, en_n, lat);
    check("t1_en_cycles", en_n, 1);
    check("t1_latency", lat, 2);
    check("t1_instr", Instr_dout, 16'h1261);
    check("t1_addr", mem_addr, 16'h3000);
    tick(1);
    // data read with 3 wait states
    Data_rd = 1; Data_addr = 16'h5000; rdata_val = 16'h00AA; wait_n = 3;
    xfer(0, en_n, lat);
    check("t4_en_cycles", en_n, 4);
    check("t4_latency", lat, 5);
    check("t4_data", Data_dout, 16'h00AA);
    tick(1);
    // data write leaves Data_dout alone
    Data_rd = 0; Data_addr = 16'h4000; Data_din = 16'hBEEF; rdata_val = 16'h1234; wait_n = 0;
    xfer(0, en_n, lat);
    check("t2_rd", mem_rd, 0);
    check("t2_wdata", mem_wdata, 16'hBEEF);
    check("t2_addr", mem_addr, 16'h4000);
    check("t2_data_kept", Data_dout, 16'h00AA);
    tick(1);
    // contention with starvation guard
    pc = 16'h3000; Data_addr = 16'h4000; Data_rd = 1; rdata_val = 16'h7777;
    instrmem_rd = 1; Data_req = 1;
    glog = ""; prev_en = 0; guard = 0;
    while (glog.len() < 10 && guard < 100) begin
      @(negedge clock);
      guard++;
      if (mem_en && !prev_en) glog = {glog, (mem_addr == 16'h3000) ? "I" : "D"};
      prev_en = mem_en;
    end
    instrmem_rd = 0; Data_req = 0;
    tests++;
    if (glog != "DDDDIDDDDI") begin
      fails++;
      $display("FAIL t3_order got=%s exp=DDDDIDDDDI", glog);
    end
    tick(4);
    // ack while idle is ignored
    stray = 1;
    tick(2);
    stray = 0;
    tick(2);
    check("stray_idle", mem_en, 0);
    // timeout on fetch, then a good fetch keeps the sticky flag
    pc = 16'h3002; no_ack = 1;
    xfer(1, en_n, lat);
    check("t5_en_cycles", en_n, 15);
    check("t5_latency", lat, 16);
    check("t5_nop", Instr_dout, 16'h0000);
    check("t5_timeout", mem_timeout, 1);
    no_ack = 0; rdata_val = 16'h5555;
    tick(1);
    xfer(1, en_n, lat);
    check("t5_good", Instr_dout, 16'h5555);
    check("t5_sticky", mem_timeout, 1);
    tick(1);
    // reset in the second busy cycle of a data read
    Data_rd = 1; Data_addr = 16'h6000; rdata_val = 16'h0BAD; wait_n = 5;
    Data_req = 1;
    tick(2);
    check("t6_busy", mem_en, 1);
    reset = 1;
    tick(1);
    check("t6_en", mem_en, 0);
    check("t6_cd", complete_data, 0);
    check("t6_addr", mem_addr, 0);
    check("t6_instr", Instr_dout, 0);
    check("t6_timeout", mem_timeout, 0);
    reset = 0;
    tick(1);
    check("t6_regrant", mem_en, 1);
    check("t6_regrant_addr", mem_addr, 16'h6000);
    guard = 0;
    while (!complete_data && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    Data_req = 0;
    check("t6_bound", guard < 40, 1);
    check("t6_data", Data_dout, 16'h0BAD);
    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
